multicycle_sequencer: RTL
=========================

// Module: multicycle_sequencer
// PURPOSE
//  Multi-cycle FSM that steps the single-issue RISC-V datapath through FETCH/DECODE/EXECUTE/MEM/WB.
//  Sits between the instruction decoder (consumes its decoded class flags) and the datapath
//  enables (IR load, PC write, regfile write, data-memory request). Handles imem/dmem req/ack
//  handshakes, bus timeouts, illegal-instruction trap, and counts retired instructions.
// PARAMETERS
//  MEM_TIMEOUT  16  max cycles a req may wait for ack before trap; 0 disables timeout
//  RETIRE_W     32  width of retired-instruction counter
// PORTS
//  clk            in   1         clock, rising edge
//  rst_n          in   1         reset, asynchronous, active-low
//  imem_ack       in   1         instruction memory returns data this cycle
//  dmem_ack       in   1         data memory access completes this cycle
//  dec_illegal    in   1         decoder: opcode/funct not recognised
//  dec_is_load    in   1         decoder: load instruction
//  dec_is_store   in   1         decoder: store instruction
//  dec_reg_write  in   1         decoder: instruction writes rd
//  imem_req       out  1         fetch request, held until ack
//  ir_load        out  1         latch instruction register
//  dmem_req       out  1         data access request, held until ack
//  dmem_we        out  1         data access is a write
//  reg_file_we    out  1         register file write strobe
//  pc_write_en    out  1         PC update strobe (= instruction retires)
//  halted         out  1         sticky trap indication
//  trap_cause     out  2         00 none, 01 imem timeout, 10 dmem timeout, 11 illegal
//  retired_count  out  RETIRE_W  retired instructions, wraps modulo 2^RETIRE_W
// BEHAVIOUR
//  - Reset (async assert, sync release): state=FETCH, wait_cnt=0, retired_count=0,
//    trap_cause=00; all strobes/reqs 0 during reset. Mid-operation reset drops reqs immediately.
//  - States (seq_state_t): FETCH, DECODE, EXECUTE, MEM, WB, TRAP.
//  - FETCH: imem_req=1. On imem_ack: ir_load=1 same cycle (comb from ack), -> DECODE.
//  - DECODE: 1 cycle. dec_illegal -> TRAP, cause 11; else -> EXECUTE.
//  - EXECUTE: 1 cycle. load|store -> MEM; else dec_reg_write -> WB;
//    else pc_write_en=1, -> FETCH (branch class).
//  - MEM: dmem_req=1, dmem_we=dec_is_store (stable while req held). On dmem_ack:
//    load -> WB; store -> pc_write_en=1, -> FETCH.
//  - WB: reg_file_we=1, pc_write_en=1 for exactly 1 cycle, -> FETCH.
//  - TRAP: halted=1, all reqs/strobes 0, trap_cause held; exit only via reset.
//  - Decoder inputs sampled only in DECODE/EXECUTE/MEM; must be stable from IR.
//  - imem_req, dmem_req, dmem_we, reg_file_we, halted: Moore (state-only). ir_load and the
//    MEM-state pc_write_en are Mealy on ack; no other comb input->output paths.
//  - Latency: ALU op 4 cycles min (F,D,E,WB), load 5, store 4, branch 3, +wait cycles.
//  - Timeout: wait_cnt clears on entry to FETCH/MEM, increments each cycle req && !ack.
//    Cycle with wait_cnt==MEM_TIMEOUT-1 and no ack -> TRAP (cause 01 in FETCH, 10 in MEM).
//    ack on that same cycle wins: normal transition, no trap. MEM_TIMEOUT=0: wait forever.
//  - retired_count increments on every pc_write_en cycle; wraps all-ones -> 0, no flag.
//  - Spurious ack outside FETCH/MEM ignored; no state change.
// STRUCTURE
//  - riscv_pkg: seq_state_t enum (3-bit), trap_cause_t enum (2-bit), TRAP_* constants.
//  - One sub-module: wait_timer (clear, enable, expire pulse; parameter MEM_TIMEOUT).
//  - FSM next-state/output logic and retire counter in this module.
// TESTING
//  - ADD, imem_ack after 2 waits: imem_req 3 cycles, ir_load 1, reg_file_we+pc_write_en at
//    cycle 6, retired_count 0->1.
//  - Load, dmem_ack immediate: state seq F,D,E,MEM,WB; dmem_we=0; reg_file_we only in WB.
//  - Store, dmem_ack after 5: dmem_we=1 held 6 cycles, pc_write_en with ack, no reg_file_we.
//  - dmem never acks, MEM_TIMEOUT=16: TRAP after 16 MEM cycles, trap_cause=10, halted=1 sticky.
//  - ack on timeout cycle -> no trap; dec_illegal in DECODE -> TRAP cause 11.
//  - rst_n low mid-MEM: dmem_req drops same cycle; after release FETCH, retired_count=0;
//    RETIRE_W=4, 16 branches -> count wraps to 0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared types for the multi-cycle RISC-V control path: sequencer states, trap causes
// and a helper that sizes the bus wait timer.
package riscv_pkg;

  typedef enum logic [2:0] {
    ST_FETCH   = 3'd0,
    ST_DECODE  = 3'd1,
    ST_EXECUTE = 3'd2,
    ST_MEM     = 3'd3,
    ST_WB      = 3'd4,
    ST_TRAP    = 3'd5
  } seq_state_t;

  typedef enum logic [1:0] {
    TRAP_NONE         = 2'b00,
    TRAP_IMEM_TIMEOUT = 2'b01,
    TRAP_DMEM_TIMEOUT = 2'b10,
    TRAP_ILLEGAL      = 2'b11
  } trap_cause_t;

  localparam int unsigned TRAP_CAUSE_W = 2;

  // Counter width able to hold 0..timeout-1; a timeout of 0 still gets a 1-bit counter.
  function automatic int unsigned timer_width(input int unsigned timeout);
    return (timeout <= 2) ? 1 : $clog2(timeout);
  endfunction

endpackage

// File: rtl/wait_timer.sv
// Counts bus wait cycles (request held without ack) and flags the cycle on which
// the allowed wait budget is exhausted.
module wait_timer
  import riscv_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire_c
);

  localparam int unsigned CNT_W    = timer_width(MEM_TIMEOUT);
  localparam int unsigned LAST_CNT = (MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1;

  logic [CNT_W-1:0] wait_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (clear) begin
      wait_cnt <= '0;
    end else if (enable) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

  // A zero budget never expires; the counter then just free-runs harmlessly.
  assign expire_c = (MEM_TIMEOUT != 0) && enable && (wait_cnt == CNT_W'(LAST_CNT));

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle control FSM stepping the single-issue datapath through fetch, decode,
// execute, memory and write-back, with bus timeouts, illegal trap and a retire counter.
module multicycle_sequencer
  import riscv_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned RETIRE_W    = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    imem_ack,
  input  logic                    dmem_ack,
  input  logic                    dec_illegal,
  input  logic                    dec_is_load,
  input  logic                    dec_is_store,
  input  logic                    dec_reg_write,
  output logic                    imem_req,
  output logic                    ir_load,
  output logic                    dmem_req,
  output logic                    dmem_we,
  output logic                    reg_file_we,
  output logic                    pc_write_en,
  output logic                    halted,
  output logic [TRAP_CAUSE_W-1:0] trap_cause,
  output logic [RETIRE_W-1:0]     retired_count
);

  seq_state_t  state_q, state_d;
  trap_cause_t cause_q, cause_d;
  logic        store_q, store_d;
  logic        armed_q;
  logic        timer_clear;
  logic        timer_enable;
  logic        timer_expire_c;

  // armed_q keeps the fetch request low while reset is asserted even though state is FETCH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FETCH;
      cause_q <= TRAP_NONE;
      store_q <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      store_q <= store_d;
      armed_q <= 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    cause_d     = cause_q;
    store_d     = store_q;
    ir_load     = 1'b0;
    pc_write_en = 1'b0;

    case (state_q)
      ST_FETCH: begin
        if (armed_q) begin
          if (imem_ack) begin
            ir_load = 1'b1;
            state_d = ST_DECODE;
          end else if (timer_expire_c) begin
            state_d = ST_TRAP;
            cause_d = TRAP_IMEM_TIMEOUT;
          end
        end
      end
      ST_DECODE: begin
        if (dec_illegal) begin
          state_d = ST_TRAP;
          cause_d = TRAP_ILLEGAL;
        end else begin
          state_d = ST_EXECUTE;
        end
      end
      ST_EXECUTE: begin
        if (dec_is_load || dec_is_store) begin
          state_d = ST_MEM;
          store_d = dec_is_store;
        end else if (dec_reg_write) begin
          state_d = ST_WB;
        end else begin
          pc_write_en = 1'b1;
          state_d     = ST_FETCH;
        end
      end
      ST_MEM: begin
        // Ack on the final budget cycle still completes the access normally.
        if (dmem_ack) begin
          if (store_q) begin
            pc_write_en = 1'b1;
            state_d     = ST_FETCH;
          end else begin
            state_d = ST_WB;
          end
        end else if (timer_expire_c) begin
          state_d = ST_TRAP;
          cause_d = TRAP_DMEM_TIMEOUT;
        end
      end
      ST_WB: begin
        pc_write_en = 1'b1;
        state_d     = ST_FETCH;
      end
      ST_TRAP: begin
        state_d = ST_TRAP;
      end
      default: begin
        state_d = ST_TRAP;
      end
    endcase
  end

  assign imem_req    = armed_q && (state_q == ST_FETCH);
  assign dmem_req    = (state_q == ST_MEM);
  assign dmem_we     = (state_q == ST_MEM) && store_q;
  assign reg_file_we = (state_q == ST_WB);
  assign halted      = (state_q == ST_TRAP);
  assign trap_cause  = cause_q;

  assign timer_enable = (imem_req && !imem_ack) || (dmem_req && !dmem_ack);
  assign timer_clear  = (state_d != state_q) && ((state_d == ST_FETCH) || (state_d == ST_MEM));

  wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_wait_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (timer_clear),
    .enable  (timer_enable),
    .expire_c(timer_expire_c)
  );

  // Every PC update is one retired instruction; wraps silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_count <= '0;
    end else if (pc_write_en) begin
      retired_count <= retired_count + RETIRE_W'(1);
    end
  end

endmodule
